// File: rtl/reg_alu_pkg.sv
// ============================================================================
// Module   : reg_alu_pkg
// Purpose  : Shared opcodes, FSM state encoding and default widths for the
//            register-file ALU sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_alu_pkg;

   localparam int c_DW = 16;
   localparam int c_AW = 3;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_NOT = 3'd5,
      OP_SHL = 3'd6,
      OP_MOV = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_EXEC  = 2'd2,
      ST_WRITE = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/reg_alu_core.sv
// ============================================================================
// Module   : reg_alu_core
// Purpose  : Combinational ALU producing a result plus zero and carry flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_alu_core
   import reg_alu_pkg::*;
#(
   parameter int DW = c_DW
) (
   input  op_t           op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] result,
   output logic          zero,
   output logic          carry
);

   logic [DW:0] w_wide;

   // One extra bit captures carry-out on ADD and borrow on SUB.
   always_comb begin
      w_wide = '0;
      result = '0;
      carry  = 1'b0;
      case (op)
         OP_ADD: begin
            w_wide = {1'b0, a} + {1'b0, b};
            result = w_wide[DW-1:0];
            carry  = w_wide[DW];
         end
         OP_SUB: begin
            w_wide = {1'b0, a} - {1'b0, b};
            result = w_wide[DW-1:0];
            carry  = w_wide[DW];
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_NOT: result = ~a;
         OP_SHL: begin
            result = {a[DW-2:0], 1'b0};
            carry  = a[DW-1];
         end
         OP_MOV: result = b;
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

`default_nettype wire

// File: rtl/reg_alu_seq.sv
// ============================================================================
// Module   : reg_alu_seq
// Purpose  : 4-cycle read/execute/write-back sequencer for an 8x16 register
//            file. Define REG_ALU_SEQ_ZERO_REG_EN to hardwire register 0 to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_alu_seq
   import reg_alu_pkg::*;
#(
   parameter int DW = c_DW,
   parameter int AW = c_AW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [2:0]    instr_op,
   input  logic [AW-1:0] instr_ra,
   input  logic [AW-1:0] instr_rb,
   input  logic [AW-1:0] instr_rd,
   output logic [AW-1:0] rf_rd_addr_a,
   output logic [AW-1:0] rf_rd_addr_b,
   input  logic [DW-1:0] rf_data_a,
   input  logic [DW-1:0] rf_data_b,
   output logic          rf_wr,
   output logic [AW-1:0] rf_wr_addr,
   output logic [DW-1:0] rf_d_in,
   output logic          done,
   output logic          flag_zero,
   output logic          flag_carry
);

   state_t        r_state;
   state_t        w_state_nxt;
   op_t           r_op;
   logic [AW-1:0] r_ra;
   logic [AW-1:0] r_rb;
   logic [AW-1:0] r_rd;
   logic [DW-1:0] r_a;
   logic [DW-1:0] r_b;
   logic [DW-1:0] r_result;
   logic          r_zero;
   logic          r_carry;

   logic [DW-1:0] w_a_in;
   logic [DW-1:0] w_b_in;
   logic          w_wr_en;
   logic [DW-1:0] w_alu_result;
   logic          w_alu_zero;
   logic          w_alu_carry;

`ifdef REG_ALU_SEQ_ZERO_REG_EN
   assign w_a_in  = (r_ra == '0) ? '0 : rf_data_a;
   assign w_b_in  = (r_rb == '0) ? '0 : rf_data_b;
   assign w_wr_en = (r_rd != '0);
`else
   assign w_a_in  = rf_data_a;
   assign w_b_in  = rf_data_b;
   assign w_wr_en = 1'b1;
`endif

   reg_alu_core #(.DW(DW)) u_core (
      .op     (r_op),
      .a      (r_a),
      .b      (r_b),
      .result (w_alu_result),
      .zero   (w_alu_zero),
      .carry  (w_alu_carry)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      instr_ready = 1'b0;
      rf_wr       = 1'b0;
      done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) w_state_nxt = ST_READ;
         end
         ST_READ:  w_state_nxt = ST_EXEC;
         ST_EXEC:  w_state_nxt = ST_WRITE;
         ST_WRITE: begin
            rf_wr       = w_wr_en;
            done        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Each stage loads only its own registers; everything else holds.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_op     <= OP_ADD;
         r_ra     <= '0;
         r_rb     <= '0;
         r_rd     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_zero   <= 1'b0;
         r_carry  <= 1'b0;
      end else begin
         if (r_state == ST_IDLE && instr_valid) begin
            r_op <= op_t'(instr_op);
            r_ra <= instr_ra;
            r_rb <= instr_rb;
            r_rd <= instr_rd;
         end
         if (r_state == ST_READ) begin
            r_a <= w_a_in;
            r_b <= w_b_in;
         end
         if (r_state == ST_EXEC) begin
            r_result <= w_alu_result;
            r_zero   <= w_alu_zero;
            r_carry  <= w_alu_carry;
         end
      end
   end

   assign rf_rd_addr_a = r_ra;
   assign rf_rd_addr_b = r_rb;
   assign rf_wr_addr   = r_rd;
   assign rf_d_in      = r_result;
   assign flag_zero    = r_zero;
   assign flag_carry   = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_reg_alu_seq.sv
// ============================================================================
// Module   : tb_reg_alu_seq
// Purpose  : Self-checking bench: sequencer plus a behavioural register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_alu_seq;

`ifdef REG_ALU_SEQ_ZERO_REG_EN
   localparam bit ZERO_EN = 1'b1;
`else
   localparam bit ZERO_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        instr_valid;
   logic        instr_ready;
   logic [2:0]  instr_op;
   logic [2:0]  instr_ra;
   logic [2:0]  instr_rb;
   logic [2:0]  instr_rd;
   logic [2:0]  rf_rd_addr_a;
   logic [2:0]  rf_rd_addr_b;
   logic [15:0] rf_data_a;
   logic [15:0] rf_data_b;
   logic        rf_wr;
   logic [2:0]  rf_wr_addr;
   logic [15:0] rf_d_in;
   logic        done;
   logic        flag_zero;
   logic        flag_carry;

   logic [15:0] rf [8];
   logic [15:0] model_rf [8];
   logic        pl_en;
   logic [2:0]  pl_addr;
   logic [15:0] pl_data;

   typedef struct {
      logic [2:0]  rd;
      logic [15:0] data;
      logic        z;
      logic        c;
      logic        wr;
   } exp_t;

   exp_t sb [$];
   int   checks = 0;
   int   errors = 0;

   reg_alu_seq #(.DW(16), .AW(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr_op     (instr_op),
      .instr_ra     (instr_ra),
      .instr_rb     (instr_rb),
      .instr_rd     (instr_rd),
      .rf_rd_addr_a (rf_rd_addr_a),
      .rf_rd_addr_b (rf_rd_addr_b),
      .rf_data_a    (rf_data_a),
      .rf_data_b    (rf_data_b),
      .rf_wr        (rf_wr),
      .rf_wr_addr   (rf_wr_addr),
      .rf_d_in      (rf_d_in),
      .done         (done),
      .flag_zero    (flag_zero),
      .flag_carry   (flag_carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural register file: combinational reads, write on rising edge.
   assign rf_data_a = rf[rf_rd_addr_a];
   assign rf_data_b = rf[rf_rd_addr_b];
   always @(posedge clk) begin
      if (pl_en)      rf[pl_addr]    <= pl_data;
      else if (rf_wr) rf[rf_wr_addr] <= rf_d_in;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] rd_model(input logic [2:0] r);
      if (ZERO_EN && r == 3'd0) return 16'h0000;
      return model_rf[r];
   endfunction

   // Reference ALU: {carry, result}
   function automatic logic [16:0] alu_model(input logic [2:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
      case (op)
         3'd0:    return {1'b0, a} + {1'b0, b};
         3'd1:    return {(a < b), 16'(a - b)};
         3'd2:    return {1'b0, a & b};
         3'd3:    return {1'b0, a | b};
         3'd4:    return {1'b0, a ^ b};
         3'd5:    return {1'b0, ~a};
         3'd6:    return {a[15], a[14:0], 1'b0};
         default: return {1'b0, b};
      endcase
   endfunction

   task automatic preload(input logic [2:0] r, input logic [15:0] v);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = r; pl_data = v;
      @(negedge clk);
      pl_en = 1'b0;
      model_rf[r] = v;
   endtask

   // Issue one instruction, then check busy/ready/done timing and pop the scoreboard.
   task automatic run(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                      input logic [2:0] rd, input bit hold, output time t_acc);
      exp_t        e;
      logic [16:0] rc;
      bit          got;
      rc     = alu_model(op, rd_model(ra), rd_model(rb));
      e.rd   = rd;
      e.data = rc[15:0];
      e.c    = rc[16];
      e.z    = (rc[15:0] == 16'h0000);
      e.wr   = !(ZERO_EN && rd == 3'd0);
      sb.push_back(e);
      instr_op = op; instr_ra = ra; instr_rb = rb; instr_rd = rd;
      instr_valid = 1'b1;
      got = 1'b0;
      t_acc = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (instr_ready) got = 1'b1;
      end
      chk("accept_timeout", 32'(got), 32'd1);
      if (!got) begin
         instr_valid = 1'b0;
         void'(sb.pop_back());
         return;
      end
      @(posedge clk);
      t_acc = $time;
      #1;
      if (!hold) instr_valid = 1'b0;
      for (int n = 1; n <= 3; n++) begin
         @(negedge clk);
         chk("ready_busy", 32'(instr_ready), 32'd0);
         if (n < 3) begin
            chk("done_early", 32'(done), 32'd0);
            chk("wr_early", 32'(rf_wr), 32'd0);
         end else begin
            chk("done_pulse", 32'(done), 32'd1);
            if (sb.size() == 0) begin
               chk("sb_empty", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("rf_wr", 32'(rf_wr), 32'(e.wr));
               chk("wr_addr", 32'(rf_wr_addr), 32'(e.rd));
               chk("d_in", 32'(rf_d_in), 32'(e.data));
               chk("flag_zero", 32'(flag_zero), 32'(e.z));
               chk("flag_carry", 32'(flag_carry), 32'(e.c));
               if (e.wr) model_rf[e.rd] = e.data;
            end
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
      chk({tag, "_wr"}, 32'(rf_wr), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_fz"}, 32'(flag_zero), 32'd0);
      chk({tag, "_fc"}, 32'(flag_carry), 32'd0);
      chk({tag, "_addr"}, {23'd0, rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr}, 32'd0);
      chk({tag, "_din"}, 32'(rf_d_in), 32'd0);
   endtask

   initial begin
      time t0, t1, t2, tx;
      bit  got;
      reset = 1'b1;
      instr_valid = 1'b0;
      instr_op = 3'd0; instr_ra = 3'd0; instr_rb = 3'd0; instr_rd = 3'd0;
      pl_en = 1'b0; pl_addr = 3'd0; pl_data = 16'h0000;
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst_init");
      @(negedge clk);
      reset = 1'b1;

      for (int r = 0; r < 8; r++) preload(3'(r), 16'h0000);
      preload(3'd0, 16'h1234);
      preload(3'd3, 16'hcdef);
      preload(3'd7, 16'h3210);

      run(3'd0, 3'd3, 3'd7, 3'd5, 1'b0, tx);
      @(negedge clk);
      chk("r5_add", 32'(rf[5]), 32'h0000ffff);

      run(3'd0, 3'd3, 3'd3, 3'd1, 1'b0, tx);
      chk("add_carry", 32'(flag_carry), 32'd1);
      run(3'd6, 3'd1, 3'd0, 3'd2, 1'b0, tx);
      @(negedge clk);
      chk("r1_add", 32'(rf[1]), 32'h00009bde);
      chk("r2_shl", 32'(rf[2]), 32'h000037bc);

      run(3'd1, 3'd7, 3'd7, 3'd4, 1'b0, tx);
      run(3'd1, 3'd7, 3'd3, 3'd6, 1'b0, tx);
      @(negedge clk);
      chk("r4_sub", 32'(rf[4]), 32'h00000000);
      chk("r6_sub", 32'(rf[6]), 32'h00006421);
      chk("sub_borrow", 32'(flag_carry), 32'd1);

      // Valid held high across three dependent instructions.
      run(3'd3, 3'd3, 3'd7, 3'd1, 1'b1, t0);
      run(3'd4, 3'd1, 3'd7, 3'd2, 1'b1, t1);
      run(3'd5, 3'd2, 3'd0, 3'd4, 1'b0, t2);
      chk("accept_gap1", 32'(t1 - t0), 32'd40);
      chk("accept_gap2", 32'(t2 - t1), 32'd40);
      @(negedge clk);
      chk("r4_not", 32'(rf[4]), 32'h00003210);

      run(3'd7, 3'd0, 3'd7, 3'd1, 1'b0, tx);
      run(3'd2, 3'd3, 3'd7, 3'd5, 1'b0, tx);
      chk("and_zero", 32'(flag_zero), 32'd1);

      // Reset while an ADD to r6 is in EXEC.
      instr_op = 3'd0; instr_ra = 3'd3; instr_rb = 3'd7; instr_rd = 3'd6;
      instr_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (instr_ready) got = 1'b1;
      end
      chk("rst_accept", 32'(got), 32'd1);
      @(posedge clk);
      #1 instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_no_wr", 32'(rf_wr), 32'd0);
         chk("rst_no_done", 32'(done), 32'd0);
      end
      reset = 1'b1;
      @(negedge clk);
      chk("r6_kept", 32'(rf[6]), 32'h00006421);
      chk("post_rst_ready", 32'(instr_ready), 32'd1);
      run(3'd0, 3'd7, 3'd7, 3'd6, 1'b0, tx);
      @(negedge clk);
      chk("r6_post_rst", 32'(rf[6]), 32'h00006420);

      // Register 0 behaviour; r0 still holds its preload.
      run(3'd7, 3'd0, 3'd0, 3'd5, 1'b0, tx);
      run(3'd0, 3'd3, 3'd7, 3'd0, 1'b0, tx);
      @(negedge clk);
`ifdef REG_ALU_SEQ_ZERO_REG_EN
      chk("r5_mov_r0", 32'(rf[5]), 32'h00000000);
      chk("r0_kept", 32'(rf[0]), 32'h00001234);
`else
      chk("r5_mov_r0", 32'(rf[5]), 32'h00001234);
      chk("r0_written", 32'(rf[0]), 32'h0000ffff);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
